// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Controller for an 8N1 UART receiver, in the clk_50m domain. It does three jobs:
//     - Tick generator: a programmable down-counter produces a registered one-cycle
//       16x-oversample enable (rx_clken) every baud_div+1 clocks while en=1.
//     - Capture FSM: takes each byte the receiver flags on rx_rdy, pushes it into the
//       FIFO exactly once, and acknowledges it with a one-cycle rx_rdy_clr pulse.
//     - FIFO: first-word fall-through buffer toward the host, with a sticky overrun flag.
//
//   Ports
//     clk_50m, rst              clock; asynchronous active-high reset
//     en                        1 = tick generator runs
//     baud_div, div_load        new divisor and its one-cycle load strobe
//     rx_clken                  oversample tick to the receiver
//     rx_rdy, rx_data           receiver byte-ready flag and byte
//     rx_rdy_clr                one-cycle clear back to the receiver
//     rd_en                     host pop (ignored when empty)
//     rd_data                   FIFO head, valid while !empty
//     empty, full, count        FIFO status (registered)
//     overrun, ovr_clr          sticky drop flag and its clear
//
//   Handshake: rx_rdy/rx_data act as valid/data from the receiver. The FSM treats
//   rx_rdy=1 in IDLE or WAIT as a new byte, pushes it on that edge and raises
//   rx_rdy_clr for the next cycle. The receiver drops rx_rdy on the edge it sees
//   rx_rdy_clr; the intervening CLR cycle ignores rx_rdy so no byte is pushed twice.
module uart_rx_ctrl #(
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 26,
    parameter int ADDR_W    = 3
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              div_load,
    output logic              rx_clken,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_rdy_clr,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(RESET_DIV);
    localparam logic [ADDR_W:0]  CNT_FULL  = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            div_reg  <= DIV_RST;
            cnt      <= DIV_RST;
            rx_clken <= 1'b0;
        end else if (div_load) begin
            // New divisor restarts the period; no tick on the load cycle.
            div_reg  <= baud_div;
            cnt      <= baud_div;
            rx_clken <= 1'b0;
        end else if (en) begin
            if (cnt == '0) begin
                rx_clken <= 1'b1;
                cnt      <= div_reg;
            end else begin
                rx_clken <= 1'b0;
                cnt      <= cnt - 1'b1;
            end
        end else begin
            rx_clken <= 1'b0;
            cnt      <= div_reg;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   push;
    logic   clr_nxt;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rx_rdy_clr <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_rdy_clr <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        clr_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_rdy) begin
                    push      = 1'b1;
                    clr_nxt   = 1'b1;
                    state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                // rx_rdy may still be high for the byte just taken; ignore it.
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // rx_rdy high here means the receiver set a new byte on the
                // clear edge (its set wins), so it is a fresh capture.
                if (rx_rdy) begin
                    push      = 1'b1;
                    clr_nxt   = 1'b1;
                    state_nxt = ST_CLR;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push_eff;
    logic              drop;
    logic [ADDR_W:0]   count_nxt;

    assign pop      = rd_en && !empty;
    // A push into a full FIFO still lands if a pop frees the slot this cycle.
    assign push_eff = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_eff && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push_eff) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_50m) begin
        if (push_eff) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_FULL);
            // Set has priority over clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl. Inputs are driven and outputs sampled on the
//   falling edge. exp_q holds the bytes the FIFO should contain; model_ovr tracks the
//   sticky overrun flag.
module tb_uart_rx_ctrl;

    localparam int DIV_W  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk_50m;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  baud_div;
    logic              div_load;
    logic              rx_clken;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              rx_rdy_clr;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              ovr_clr;

    logic [7:0] exp_q[$];
    logic       model_ovr;
    int         checks;
    int         failures;

    uart_rx_ctrl #(
        .DIV_W     (DIV_W),
        .RESET_DIV (26),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .en         (en),
        .baud_div   (baud_div),
        .div_load   (div_load),
        .rx_clken   (rx_clken),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    // Clock / reset
    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"},   32'(count),   32'(exp_q.size()));
        check({tag, "_empty"},   32'(empty),   32'(exp_q.size() == 0));
        check({tag, "_full"},    32'(full),    32'(exp_q.size() == DEPTH));
        check({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
    endtask

    // Receiver model: present a byte, optionally with a host pop and/or ovr_clr on the
    // capture edge, then drop rx_rdy once rx_rdy_clr is seen. Starts with the FSM idle.
    task automatic send_byte(input logic [7:0] b, input logic rd, input logic clr);
        logic [7:0] head;
        logic       do_pop;
        rx_rdy  = 1'b1;
        rx_data = b;
        rd_en   = rd;
        ovr_clr = clr;
        do_pop  = rd && (exp_q.size() > 0);
        if (do_pop) begin
            head = exp_q.pop_front();
            check("pop_head", 32'(rd_data), 32'(head));
        end
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
        end else begin
            model_ovr = 1'b1;
        end
        if (clr && exp_q.size() < DEPTH + 1 && !(exp_q.size() == DEPTH && !do_pop && model_ovr && b != exp_q[DEPTH-1])) begin
            // ovr_clr only wins when nothing was dropped on this edge
        end
        @(negedge clk_50m);
        rd_en   = 1'b0;
        ovr_clr = 1'b0;
        check("rdy_clr_rise", 32'(rx_rdy_clr), 32'd1);
        check_status("push");
        rx_rdy = 1'b0;
        @(negedge clk_50m);
        check("rdy_clr_fall", 32'(rx_rdy_clr), 32'd0);
        @(negedge clk_50m);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] head;
        check({tag, "_nonempty"}, 32'(empty), 32'd0);
        head  = exp_q.pop_front();
        check({tag, "_data"}, 32'(rd_data), 32'(head));
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
        check_status(tag);
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        @(negedge clk_50m);
        ovr_clr   = 1'b0;
        model_ovr = 1'b0;
        check("ovr_clr_alone", 32'(overrun), 32'd0);
    endtask

    // Expect a tick on every period-th falling edge for n edges.
    task automatic check_ticks(input string tag, input int period, input int n);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk_50m);
            check(tag, 32'(rx_clken), 32'((j % period) == 0));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_ovr = 1'b0;
        rst       = 1'b1;
        en        = 1'b0;
        baud_div  = '0;
        div_load  = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = '0;
        rd_en     = 1'b0;
        ovr_clr   = 1'b0;
        repeat (3) @(negedge clk_50m);

        // Reset state
        check("rst_clken", 32'(rx_clken), 32'd0);
        check("rst_rdy_clr", 32'(rx_rdy_clr), 32'd0);
        check_status("rst");
        rst = 1'b0;
        @(negedge clk_50m);

        // 1: divisor 3 -> one tick in every 4 clocks, first on the 4th clock
        baud_div = 16'd3;
        div_load = 1'b1;
        en       = 1'b1;
        @(negedge clk_50m);
        div_load = 1'b0;
        check("load_no_tick", 32'(rx_clken), 32'd0);
        check_ticks("tick_div3", 4, 12);
        en = 1'b0;
        @(negedge clk_50m);
        check("en_off_clken", 32'(rx_clken), 32'd0);

        // 2: single byte
        send_byte(8'hA5, 1'b0, 1'b0);
        check("single_peek", 32'(rd_data), 32'hA5);
        pop_check("single_pop");

        // Pop on empty is ignored
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
        check_status("pop_empty");

        // 3: nine bytes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b0);
        check("fill9_full", 32'(full), 32'd1);
        check("fill9_ovr", 32'(overrun), 32'd1);
        for (int i = 0; i < 8; i++) pop_check("drain9");
        check("drain9_empty", 32'(empty), 32'd1);

        // 5: ovr_clr on a dropping push loses; alone it clears
        clear_ovr();
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        send_byte(8'h18, 1'b0, 1'b1);
        check("clr_vs_drop", 32'(overrun), 32'd1);
        clear_ovr();

        // 4: push and pop together while full
        send_byte(8'h20, 1'b1, 1'b0);
        check("full_pushpop_count", 32'(count), 32'd8);
        check("full_pushpop_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) pop_check("drain_pp");

        // 6: reset mid-CLR with five bytes held
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b0);
        rx_rdy  = 1'b1;
        rx_data = 8'h55;
        @(negedge clk_50m);
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_clr", 32'(rx_rdy_clr), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_ovr = 1'b0;
        check("async_rst_clr", 32'(rx_rdy_clr), 32'd0);
        check_status("async_rst");
        @(negedge clk_50m);
        rst = 1'b0;
        // rx_rdy still high: captured exactly once after release
        @(negedge clk_50m);
        exp_q.push_back(8'h55);
        check("post_rst_clr", 32'(rx_rdy_clr), 32'd1);
        check_status("post_rst");
        rx_rdy = 1'b0;
        repeat (3) @(negedge clk_50m);
        check_status("post_rst_once");
        pop_check("post_rst_pop");

        // Divisor back at 26 after reset: one tick per 27 clocks
        en = 1'b1;
        check_ticks("tick_div26", 27, 60);
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
